// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder stage. A start in IDLE captures two WIDTH-bit operands
//   and a carry-in into internal shift registers. A single full-adder cell
//   then consumes one bit pair per clock, LSB first, with the carry kept in a
//   flop. After WIDTH RUN cycles the assembled sum and the final carry are
//   published, and done pulses for one cycle.
//
//   Optional feature: define SERIAL_ADD_SUB_EN to add the sub port. With
//   sub=1 the stage loads ~b and forces the carry to 1, so it computes a-b.
//   In that mode cout=1 means no borrow.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request, sampled only in IDLE
//   a, b      in   WIDTH  operands, captured on an accepted start
//   cin       in   1      carry-in, captured on an accepted start
//   sub       in   1      subtract select (only with SERIAL_ADD_SUB_EN)
//   busy      out  1      high whenever the FSM is not in IDLE
//   done      out  1      one-cycle pulse, sum/cout newly updated
//   sum       out  WIDTH  registered result, held until the next completion
//   cout      out  1      registered carry-out, held until the next completion
//   dbg_state out  2      current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a start that is high at a clock edge while busy=0 is accepted at
// that edge. A start that is high while busy=1 is ignored. done is high for
// exactly the one cycle after the edge that writes sum/cout.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit, carry_nxt;
   logic [WIDTH-1:0] res_nxt;

   // Full-adder cell working on the current LSBs of the shift registers.
   always_comb begin
      s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
      carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
      res_nxt   = {s_bit, res_sh[WIDTH-1:1]};
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                  // Two's-complement subtract: a + ~b + 1, cin is ignored.
                  if (sub) begin
                     b_sh  <= ~b;
                     carry <= 1'b1;
                  end
`endif
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= carry_nxt;
               res_sh <= res_nxt;
               cnt    <= cnt + CW'(1);
               // Publish on the last bit. The result uses the freshly shifted
               // word, so sum never shows a partial value.
               if (cnt == LAST) begin
                  sum  <= res_nxt;
                  cout <= carry_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
